rgb_pixel_fifo: RTL and testbench

Wishbone-slave pixel buffer directly upstream of the WS2812 serializer. The CPU pushes 24-bit GRB words into a DEPTH-entry FIFO and marks end-of-frame. The serializer pops words over a valid/ready handshake. When the committed frame has drained, the block pulses `frame_end` so the serializer can insert the ≥50 µs latch gap.

---
 rtl/rgb_pixel_fifo.sv | 256 +++++++++++++++++++++++++
 tb/tb_rgb_pixel_fifo.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pixel_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_pixel_fifo
//  Purpose  : Wishbone-slave GRB pixel buffer feeding the WS2812 serializer.
//             The CPU pushes 24-bit words and marks end-of-frame. The
//             serializer pops words over valid/ready. A one-cycle frame_end
//             pulse is raised once a committed frame has fully drained.
//  Options  : RGBFIFO_IRQ_EN - adds the irq output and WMARK register.
//  Revision : 1.0 - initial release
// ============================================================================
module rgb_pixel_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic        clkin,
    input  logic        resetn,
    // Wishbone slave
    input  logic        slv_ext_stb_o,
    input  logic        slv_ext_cyc_o,
    input  logic        slv_ext_we_o,
    input  logic [3:0]  slv_ext_adr_o,
    input  logic [31:0] slv_ext_wdata_o,
    input  logic [3:0]  slv_ext_sel_o,
    output logic        slv_ext_ack_i,
    output logic [31:0] slv_ext_rdata_i,
    // Pixel stream to the serializer
    output logic        pix_valid,
    output logic [23:0] pix_data,
    input  logic        pix_ready,
    output logic        frame_end
`ifdef RGBFIFO_IRQ_EN
    ,
    output logic        irq
`endif
);

    // Register map
    localparam logic [3:0] c_REG_DATA   = 4'd0;
    localparam logic [3:0] c_REG_STATUS = 4'd1;
    localparam logic [3:0] c_REG_CTRL   = 4'd2;
`ifdef RGBFIFO_IRQ_EN
    localparam logic [3:0] c_REG_WMARK  = 4'd3;
`endif

    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [23:0]       r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;

    logic              r_ack;
    logic [31:0]       r_rdata;

    logic              r_overflow;
    logic              r_underrun;
    logic              r_eof_pending;
    logic              r_frame_active;
    logic              r_frame_end;

`ifdef RGBFIFO_IRQ_EN
    logic [ADDR_W:0]   r_wmark;
    logic              r_irq;
`endif

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic        w_acc;
    logic        w_wr;
    logic        w_push;
    logic        w_ctrl_wr;
    logic        w_flush;
    logic        w_eof_wr;
    logic        w_clr_flags;
    logic        w_empty;
    logic        w_full;
    logic        w_push_ok;
    logic        w_pop;
    logic        w_ovf_set;
    logic        w_und_set;
    logic        w_fe_fire;
    logic [31:0] w_status;
    logic [31:0] w_rd_value;
    logic        w_unused_bits;

    // A new access is seen exactly once: the cycle before ack rises.
    assign w_acc       = slv_ext_stb_o & slv_ext_cyc_o & ~r_ack;
    assign w_wr        = w_acc & slv_ext_we_o;
    assign w_push      = w_wr & (slv_ext_adr_o == c_REG_DATA);
    assign w_ctrl_wr   = w_wr & (slv_ext_adr_o == c_REG_CTRL);
    assign w_flush     = w_ctrl_wr & slv_ext_wdata_o[0];
    assign w_eof_wr    = w_ctrl_wr & slv_ext_wdata_o[1];
    assign w_clr_flags = w_ctrl_wr & slv_ext_wdata_o[2];

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_DEPTH);

    // A push into a full FIFO is dropped even when a pop frees a slot in
    // the same cycle; the head word is never overwritten.
    assign w_push_ok   = w_push & ~w_full;
    // Flush wins over a concurrent pop.
    assign w_pop       = ~w_empty & pix_ready & ~w_flush;
    assign w_ovf_set   = w_push & w_full;
    // Serializer asking for data mid-frame with nothing committed as the end.
    assign w_und_set   = pix_ready & w_empty & r_frame_active & ~r_eof_pending;
    // Frame handed off: eof marked, nothing left and nothing arriving.
    assign w_fe_fire   = r_eof_pending & w_empty & ~w_push & ~w_flush;

    // Byte selects are not supported and the top data byte carries nothing.
    assign w_unused_bits = ^{slv_ext_sel_o, slv_ext_wdata_o[31:24]};

    // STATUS register image
    always_comb begin
        w_status             = '0;
        w_status[ADDR_W:0]   = r_count;
        w_status[16]         = w_empty;
        w_status[17]         = w_full;
        w_status[18]         = r_overflow;
        w_status[19]         = r_underrun;
        w_status[20]         = r_eof_pending;
    end

    // Read-data multiplexer; write-only and unmapped addresses read as 0
    always_comb begin
        w_rd_value = '0;
        case (slv_ext_adr_o)
            c_REG_STATUS: w_rd_value = w_status;
`ifdef RGBFIFO_IRQ_EN
            c_REG_WMARK:  w_rd_value[ADDR_W:0] = r_wmark;
`endif
            default:      w_rd_value = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Wishbone handshake and registered read data
    // ------------------------------------------------------------------
    // Ack follows each accepted access for one cycle; rdata captured alongside
    always_ff @(posedge clkin) begin
        if (!resetn) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack <= w_acc;
            if (w_acc) begin
                r_rdata <= slv_ext_we_o ? 32'd0 : w_rd_value;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    // Pixel memory: no reset, written only by accepted pushes
    always_ff @(posedge clkin) begin
        if (resetn && w_push_ok) begin
            r_mem[r_wr_ptr] <= slv_ext_wdata_o[23:0];
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally modulo DEPTH
    always_ff @(posedge clkin) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame tracking and sticky error flags
    // ------------------------------------------------------------------
    // eof/frame bookkeeping, frame_end pulse, and sticky overflow/underrun
    always_ff @(posedge clkin) begin
        if (!resetn) begin
            r_eof_pending  <= 1'b0;
            r_frame_active <= 1'b0;
            r_frame_end    <= 1'b0;
            r_overflow     <= 1'b0;
            r_underrun     <= 1'b0;
        end else begin
            r_frame_end <= w_fe_fire;

            // A fresh eof written on the firing cycle starts the next frame.
            if (w_flush) begin
                r_eof_pending <= 1'b0;
            end else if (w_eof_wr) begin
                r_eof_pending <= 1'b1;
            end else if (w_fe_fire) begin
                r_eof_pending <= 1'b0;
            end

            if (w_flush || w_fe_fire) begin
                r_frame_active <= 1'b0;
            end else if (w_pop) begin
                r_frame_active <= 1'b1;
            end

            // An event on the clearing cycle is kept rather than lost.
            r_overflow <= (r_overflow & ~w_clr_flags) | w_ovf_set;
            r_underrun <= (r_underrun & ~w_clr_flags) | w_und_set;
        end
    end

`ifdef RGBFIFO_IRQ_EN
    // ------------------------------------------------------------------
    // Low-watermark interrupt
    // ------------------------------------------------------------------
    // WMARK register and registered low-watermark interrupt
    always_ff @(posedge clkin) begin
        if (!resetn) begin
            r_wmark <= '0;
            r_irq   <= 1'b0;
        end else begin
            if (w_wr && (slv_ext_adr_o == c_REG_WMARK)) begin
                r_wmark <= slv_ext_wdata_o[ADDR_W:0];
            end
            r_irq <= ~w_flush & ~r_eof_pending & r_frame_active &
                     (r_count <= r_wmark);
        end
    end

    assign irq = r_irq;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign slv_ext_ack_i   = r_ack;
    assign slv_ext_rdata_i = r_rdata;
    assign pix_valid       = ~w_empty;
    assign pix_data        = r_mem[r_rd_ptr];
    assign frame_end       = r_frame_end;

endmodule
`default_nettype wire

// File: tb/tb_rgb_pixel_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rgb_pixel_fifo
//  Purpose  : Self-checking bench for rgb_pixel_fifo. A queue-based model
//             tracks the expected FIFO contents and flags; every cycle the
//             DUT outputs are compared against it. Directed scenarios pin
//             the model with hand-computed values, then random traffic runs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_pixel_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic        clkin = 1'b0;
    logic        resetn;
    logic        stb, cyc, we;
    logic [3:0]  adr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        ack;
    logic [31:0] rdata;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic        pix_ready;
    logic        frame_end;
`ifdef RGBFIFO_IRQ_EN
    logic        irq;
`endif

    int errors = 0;
    int checks = 0;
    int fe_seen = 0;
    bit chk_en = 0;
    bit rand_stop = 0;

    rgb_pixel_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clkin           (clkin),
        .resetn          (resetn),
        .slv_ext_stb_o   (stb),
        .slv_ext_cyc_o   (cyc),
        .slv_ext_we_o    (we),
        .slv_ext_adr_o   (adr),
        .slv_ext_wdata_o (wdata),
        .slv_ext_sel_o   (sel),
        .slv_ext_ack_i   (ack),
        .slv_ext_rdata_i (rdata),
        .pix_valid       (pix_valid),
        .pix_data        (pix_data),
        .pix_ready       (pix_ready),
        .frame_end       (frame_end)
`ifdef RGBFIFO_IRQ_EN
        ,
        .irq             (irq)
`endif
    );

    always #5 clkin = ~clkin;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: FIFO as a queue, flags as bits
    // ------------------------------------------------------------------
    logic [23:0] mq[$];
    bit          m_ack, m_fe, m_irq, m_eof, m_fa, m_ovf, m_und;
    logic [31:0] m_rdata;
    int          m_wmark;

    always @(posedge clkin) begin : p_model
        int cnt;
        bit acc, push, ctrl, flush, eofw, clr, pop, fire, und_set, ovf_set;
        logic [31:0] st;
        logic [23:0] tmp;
        if (!resetn) begin
            mq.delete();
            m_ack = 0; m_fe = 0; m_irq = 0; m_eof = 0; m_fa = 0;
            m_ovf = 0; m_und = 0; m_rdata = 0; m_wmark = 0;
        end else begin
            cnt   = mq.size();
            acc   = stb && cyc && !m_ack;
            push  = acc && we && adr == 4'd0;
            ctrl  = acc && we && adr == 4'd2;
            flush = ctrl && wdata[0];
            eofw  = ctrl && wdata[1];
            clr   = ctrl && wdata[2];
            st = 32'(cnt);
            st[16] = (cnt == 0);
            st[17] = (cnt == DEPTH);
            st[18] = m_ovf;
            st[19] = m_und;
            st[20] = m_eof;
            if (acc) begin
                if (we) m_rdata = 0;
                else if (adr == 4'd1) m_rdata = st;
`ifdef RGBFIFO_IRQ_EN
                else if (adr == 4'd3) m_rdata = 32'(m_wmark);
`endif
                else m_rdata = 0;
            end
            m_ack   = acc;
            pop     = cnt > 0 && pix_ready && !flush;
            und_set = pix_ready && cnt == 0 && m_fa && !m_eof;
            ovf_set = push && cnt == DEPTH;
            fire    = m_eof && cnt == 0 && !push && !flush;
            m_irq   = !flush && !m_eof && m_fa && cnt <= m_wmark;
            m_fe    = fire;
            m_ovf   = (m_ovf && !clr) || ovf_set;
            m_und   = (m_und && !clr) || und_set;
            if (flush) begin
                mq.delete();
                m_eof = 0;
                m_fa  = 0;
            end else begin
                if (pop) begin
                    tmp  = mq.pop_front();
                    m_fa = 1;
                end
                if (push && cnt < DEPTH) mq.push_back(wdata[23:0]);
                if (fire) begin
                    m_eof = 0;
                    m_fa  = 0;
                end
                if (eofw) m_eof = 1;
            end
`ifdef RGBFIFO_IRQ_EN
            if (acc && we && adr == 4'd3) m_wmark = int'(wdata[ADDR_W:0]);
`endif
        end
    end

    // Compare process: DUT outputs against the model, mid-cycle
    always @(negedge clkin) begin
        if (chk_en) begin
            check("ack", 32'(ack), 32'(m_ack));
            if (m_ack) check("rdata", rdata, m_rdata);
            check("pix_valid", 32'(pix_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) check("pix_data", 32'(pix_data), 32'(mq[0]));
            check("frame_end", 32'(frame_end), 32'(m_fe));
`ifdef RGBFIFO_IRQ_EN
            check("irq", 32'(irq), 32'(m_irq));
`endif
            if (frame_end) fe_seen++;
        end
    end

    // ------------------------------------------------------------------
    // Wishbone master tasks (called at posedge+1)
    // ------------------------------------------------------------------
    task automatic wait_ack();
        int n = 0;
        do begin
            @(negedge clkin);
            n++;
        end while (!ack && n < 20);
        check("wb_ack_seen", 32'(ack), 32'd1);
    endtask

    task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
        stb = 1; cyc = 1; we = 1; adr = a; wdata = d;
        wait_ack();
        @(posedge clkin); #1;
        stb = 0; cyc = 0; we = 0;
    endtask

    task automatic wb_read(input logic [3:0] a, output logic [31:0] d);
        stb = 1; cyc = 1; we = 0; adr = a; wdata = 0;
        wait_ack();
        d = rdata;
        @(posedge clkin); #1;
        stb = 0; cyc = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int fe0;
        resetn = 0; stb = 0; cyc = 0; we = 0; adr = 0; wdata = 0; sel = 4'hF; pix_ready = 0;
        @(posedge clkin); #1;
        chk_en = 1;
        idle(2);
        resetn = 1;
        idle(1);

        // Reset state
        wb_read(4'd1, rd);
        check("reset_status", rd, 32'h0001_0000);
        check("reset_valid", 32'(pix_valid), 32'd0);

        // Two pushes, consecutive pops
        wb_write(4'd0, 32'h0011_2233);
        wb_write(4'd0, 32'h0044_5566);
        pix_ready = 1;
        @(negedge clkin);
        check("pop0_data", 32'(pix_data), 32'h0011_2233);
        @(negedge clkin);
        check("pop1_data", 32'(pix_data), 32'h0044_5566);
        check("pop1_valid", 32'(pix_valid), 32'd1);
        @(negedge clkin);
        check("drained_valid", 32'(pix_valid), 32'd0);
        @(posedge clkin); #1;
        pix_ready = 0;

        // Overflow: DEPTH+1 pushes with no consumer
        wb_write(4'd2, 32'd5);
        for (int i = 0; i <= DEPTH; i++) wb_write(4'd0, 32'h00A0_0000 + 32'(i));
        wb_read(4'd1, rd);
        check("full_status", rd, 32'h0006_0010);
        check("full_head", 32'(pix_data), 32'h00A0_0000);
        wb_write(4'd2, 32'd4);
        wb_read(4'd1, rd);
        check("ovf_cleared", rd, 32'h0002_0010);
        wb_write(4'd2, 32'd1);
        wb_read(4'd1, rd);
        check("flushed_status", rd, 32'h0001_0000);

        // Frame end after draining a committed frame
        wb_write(4'd0, 32'h0000_00C1);
        wb_write(4'd0, 32'h0000_00C2);
        wb_write(4'd0, 32'h0000_00C3);
        wb_write(4'd2, 32'd2);
        fe0 = fe_seen;
        pix_ready = 1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clkin);
            check("fe_timing", 32'(frame_end), 32'(k == 4));
        end
        @(posedge clkin); #1;
        pix_ready = 0;
        check("fe_count", 32'(fe_seen - fe0), 32'd1);
        wb_read(4'd1, rd);
        check("eof_cleared", rd, 32'h0001_0000);

        // Underrun, then flush mid-stream without frame_end
        wb_write(4'd0, 32'h0000_00D1);
        wb_write(4'd0, 32'h0000_00D2);
        pix_ready = 1;
        idle(5);
        pix_ready = 0;
        wb_read(4'd1, rd);
        check("underrun_status", rd, 32'h0009_0000);
        fe0 = fe_seen;
        for (int i = 0; i < 3; i++) wb_write(4'd0, 32'h00E0_0000 + 32'(i));
        wb_write(4'd2, 32'd1);
        idle(3);
        wb_read(4'd1, rd);
        check("flush_status", rd, 32'h0009_0000);
        check("flush_no_fe", 32'(fe_seen - fe0), 32'd0);
        wb_write(4'd2, 32'd4);

`ifdef RGBFIFO_IRQ_EN
        // Low-watermark interrupt
        wb_write(4'd3, 32'd2);
        wb_read(4'd3, rd);
        check("wmark_read", rd, 32'd2);
        for (int i = 0; i < 4; i++) wb_write(4'd0, 32'h00F0_0000 + 32'(i));
        pix_ready = 1;
        idle(6);
        pix_ready = 0;
        check("irq_high", 32'(irq), 32'd1);
        wb_write(4'd2, 32'd2);
        idle(3);
        check("irq_low_after_eof", 32'(irq), 32'd0);
        wb_write(4'd2, 32'd5);
`endif

        // Random traffic, model-checked every cycle
        fork
            begin
                for (int n = 0; n < 600; n++) begin
                    int op;
                    logic [31:0] v;
                    op = int'($urandom_range(0, 19));
                    if (op < 9) begin
                        wb_write(4'd0, $urandom);
                    end else if (op < 11) begin
                        wb_read(4'd1, rd);
                    end else if (op < 13) begin
                        v = 32'($urandom_range(0, 7));
                        if ($urandom_range(0, 5) != 0) v[0] = 1'b0;
                        wb_write(4'd2, v);
                    end else if (op < 15) begin
                        wb_read(4'($urandom_range(0, 15)), rd);
                    end else if (op < 17) begin
                        wb_write(4'($urandom_range(3, 15)), 32'($urandom_range(0, DEPTH)));
                    end else if (op == 19 && $urandom_range(0, 9) == 0) begin
                        resetn = 0;
                        idle(2);
                        resetn = 1;
                    end else begin
                        idle(int'($urandom_range(1, 6)));
                    end
                end
                rand_stop = 1;
            end
            begin
                while (!rand_stop) begin
                    @(posedge clkin); #1;
                    pix_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        pix_ready = 0;
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
